// File: rtl/laser_pkg.sv
// laser_pkg: shared constants and state encoding
// for the two-circle laser coverage scheduler.
package laser_pkg;

  localparam int NPTS       = 40;
  localparam int LANES      = 2;
  localparam int MAX_ROUNDS = 4;
  localparam int GRID       = 16;

  localparam int BEATS = NPTS / LANES;

  localparam int CW = 4;
  localparam int PW = 6;

  localparam int RW = $clog2(MAX_ROUNDS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    ROUND,
    FIN
  } state_t;

endpackage

// File: rtl/laser_cand_cnt.sv
// laser_cand_cnt: beat counter nested inside the
// candidate-centre sweep (X low, Y high).
module laser_cand_cnt
  import laser_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          en,
  input  logic          clr,
  output logic [PW-1:0] beat,
  output logic [CW-1:0] cand_x,
  output logic [CW-1:0] cand_y,
  output logic          last_beat,
  output logic          last_cand
);

  logic last_x;
  logic last_y;

  assign last_beat = (beat == PW'(BEATS - 1));
  assign last_x    = (cand_x == CW'(GRID - 1));
  assign last_y    = (cand_y == CW'(GRID - 1));
  assign last_cand = last_x && last_y;

  // Advance beat; roll candidate after its last beat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      beat   <= '0;
      cand_x <= '0;
      cand_y <= '0;
    end else if (clr) begin
      beat   <= '0;
      cand_x <= '0;
      cand_y <= '0;
    end else if (en) begin
      if (last_beat) begin
        beat <= '0;
        if (last_x) begin
          cand_x <= '0;
          if (last_y) begin
            cand_y <= '0;
          end else begin
            cand_y <= cand_y + 1'b1;
          end
        end else begin
          cand_x <= cand_x + 1'b1;
        end
      end else begin
        beat <= beat + 1'b1;
      end
    end
  end

endmodule

// File: rtl/laser_scan_sched.sv
// laser_scan_sched: load / scan / finish sequencer.
// Optional LASER_EARLY_EXIT_EN adds best_changed.
module laser_scan_sched
  import laser_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [PW-1:0] wr_addr,
  input  logic          dp_stall,
`ifdef LASER_EARLY_EXIT_EN
  input  logic          best_changed,
`endif
  output logic [CW-1:0] cand_x,
  output logic [CW-1:0] cand_y,
  output logic          sel_circle,
  output logic          use_other,
  output logic [PW-1:0] pt_idx,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          cand_last,
  output logic          tie_ge,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [RW-1:0] r;
  logic [RW-1:0] r_nx;
  logic [PW-1:0] beat;
  logic          scan_go;
  logic          cnt_clr;
  logic          last_beat;
  logic          last_cand;
  logic          round_end;
  logic          early;

  assign scan_go = (state == SCAN) && !dp_stall;
  assign cnt_clr = (state == IDLE);

  laser_cand_cnt u_cnt (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .en        (scan_go),
    .clr       (cnt_clr),
    .beat      (beat),
    .cand_x    (cand_x),
    .cand_y    (cand_y),
    .last_beat (last_beat),
    .last_cand (last_cand)
  );

  assign wr_en     = (state == LOAD) && in_valid;
  assign pt_idx    = beat;
  assign acc_en    = scan_go;
  assign acc_clr   = scan_go && (beat == '0);
  assign cand_last = scan_go && last_beat;
  assign round_end = cand_last && last_cand;
  assign r_nx      = r + 1'b1;

`ifdef LASER_EARLY_EXIT_EN
  logic sticky;

  assign early = (r >= RW'(2)) && !sticky;

  // Remember whether any candidate in this round improved the best.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sticky <= 1'b0;
    end else if (state == ROUND || state == IDLE) begin
      sticky <= 1'b0;
    end else if (cand_last && best_changed) begin
      sticky <= 1'b1;
    end
  end
`else
  assign early = 1'b0;
`endif

  // Job sequencer with registered status and round policy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
      wr_addr    <= '0;
      r          <= '0;
      sel_circle <= 1'b0;
      use_other  <= 1'b0;
      tie_ge     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            busy       <= 1'b1;
            in_ready   <= 1'b1;
            wr_addr    <= '0;
            r          <= '0;
            sel_circle <= 1'b0;
            use_other  <= 1'b0;
            tie_ge     <= 1'b0;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (wr_addr == PW'(NPTS - 1)) begin
              wr_addr  <= '0;
              in_ready <= 1'b0;
              state    <= SCAN;
            end else begin
              wr_addr <= wr_addr + 1'b1;
            end
          end
        end
        SCAN: begin
          if (round_end) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          r <= r_nx;
          if (r_nx == RW'(MAX_ROUNDS) || early) begin
            state <= FIN;
          end else begin
            state      <= SCAN;
            sel_circle <= r_nx[0];
            use_other  <= 1'b1;
            tie_ge     <= (r_nx >= RW'(2));
          end
        end
        FIN: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
          r          <= '0;
          sel_circle <= 1'b0;
          use_other  <= 1'b0;
          tie_ge     <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_scan_sched.sv
// tb_laser_scan_sched: scoreboard bench for the
// laser scan scheduler (default and early-exit builds).
module tb_laser_scan_sched;
  import laser_pkg::*;

`ifdef LASER_EARLY_EXIT_EN
  localparam int EXP_ROUNDS = 3;
`else
  localparam int EXP_ROUNDS = MAX_ROUNDS;
`endif
  localparam int NCAND    = GRID * GRID;
  localparam int BASE_LAT = NPTS + EXP_ROUNDS * (NCAND * BEATS + 1) + 1;

  typedef struct packed {
    logic [3:0] cx;
    logic [3:0] cy;
    logic [5:0] pt;
    logic       clr;
    logic       last;
    logic       sel;
    logic       uo;
    logic       tie;
  } beat_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b1;
  logic       in_valid = 1'b1;
  logic       dp_stall = 1'b1;
  logic       in_ready;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [3:0] cand_x;
  logic [3:0] cand_y;
  logic       sel_circle;
  logic       use_other;
  logic [5:0] pt_idx;
  logic       acc_clr;
  logic       acc_en;
  logic       cand_last;
  logic       tie_ge;
  logic       busy;
  logic       done;
`ifdef LASER_EARLY_EXIT_EN
  logic       best_changed = 1'b0;
`endif

  laser_scan_sched dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .dp_stall     (dp_stall),
`ifdef LASER_EARLY_EXIT_EN
    .best_changed (best_changed),
`endif
    .cand_x       (cand_x),
    .cand_y       (cand_y),
    .sel_circle   (sel_circle),
    .use_other    (use_other),
    .pt_idx       (pt_idx),
    .acc_clr      (acc_clr),
    .acc_en       (acc_en),
    .cand_last    (cand_last),
    .tie_ge       (tie_ge),
    .busy         (busy),
    .done         (done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  int start_cyc = 0;

  beat_t      exp_q[$];
  logic [5:0] addr_q[$];
  int         lat_q[$];

  int          obs_bad, obs_stall_bad, obs_lasts;
  int          obs_done_n, obs_done_lat, obs_busy_bad;
  int          obs_first, obs_post_bad, obs_timeout;
  int          obs_fm_i;
  beat_t       obs_first_b, obs_fm_got, obs_fm_exp;
  logic [29:0] obs_abort_val;
  logic [2:0]  obs_pol[$];

  function automatic logic [29:0] all_outs();
    return {in_ready, wr_en, wr_addr, cand_x, cand_y,
            sel_circle, use_other, pt_idx, acc_clr,
            acc_en, cand_last, tie_ge, busy, done};
  endfunction

  task automatic build_model();
    beat_t e;
    exp_q.delete();
    for (int r = 0; r < EXP_ROUNDS; r++)
      for (int c = 0; c < NCAND; c++)
        for (int b = 0; b < BEATS; b++) begin
          e.cx   = 4'(c % GRID);
          e.cy   = 4'(c / GRID);
          e.pt   = 6'(b);
          e.clr  = (b == 0);
          e.last = (b == BEATS - 1);
          e.sel  = (r % 2 == 1);
          e.uo   = (r != 0);
          e.tie  = (r >= 2);
          exp_q.push_back(e);
        end
  endtask

  task automatic start_job();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic load_pts(input bit gaps, output int errs);
    logic [5:0] a;
    errs = 0;
    for (int i = 0; i < NPTS; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        #1;
        if (wr_en !== 1'b0 || wr_addr !== 6'(i) || in_ready !== 1'b1)
          errs++;
        @(negedge CLK);
      end
      in_valid = 1'b1;
      addr_q.push_back(6'(i));
      #1;
      a = addr_q.pop_front();
      if (wr_en !== 1'b1 || wr_addr !== a || in_ready !== 1'b1)
        errs++;
      if (i != NPTS - 1) @(negedge CLK);
    end
  endtask

  task automatic watch_job(input int stall_len, input bit stall_round,
                           input int mid_start, input int fin_start,
                           input int abort_at, input int budget);
    beat_t o, e;
    int    stall_left, rs, popped;
    bit    round_next;
    obs_bad = 0; obs_stall_bad = 0; obs_lasts = 0;
    obs_done_n = 0; obs_done_lat = -1; obs_busy_bad = 0;
    obs_first = -1; obs_post_bad = 0; obs_timeout = 0;
    obs_fm_i = -1; obs_first_b = '0; obs_abort_val = '1;
    obs_pol.delete();
    stall_left = stall_len;
    round_next = 1'b0;
    popped = 0;
    forever begin
      @(posedge CLK);
      #1;
      in_valid = 1'b0;
      dp_stall = 1'b0;
      start    = 1'b0;
      rs = cyc - start_cyc;
      if (abort_at > 0 && rs == abort_at) begin
        RST_N = 1'b0;
        @(negedge CLK);
        obs_abort_val = all_outs();
        return;
      end
      if (round_next && stall_round) dp_stall = 1'b1;
      if (stall_left > 0 && exp_q.size() > 0)
        if (exp_q[0].cx == 4'd5 && exp_q[0].cy == 4'd2 &&
            exp_q[0].pt == 6'd7 && !exp_q[0].uo) begin
          dp_stall = 1'b1;
          stall_left--;
        end
      if (mid_start > 0 && rs == mid_start) start = 1'b1;
      if (fin_start > 0 && rs == fin_start) start = 1'b1;
      @(negedge CLK);
      round_next = 1'b0;
      if (!done && busy !== 1'b1) obs_busy_bad++;
      if (dp_stall && (acc_en || acc_clr || cand_last)) obs_stall_bad++;
      if (acc_en === 1'b1) begin
        o = '{cx: cand_x, cy: cand_y, pt: pt_idx, clr: acc_clr,
              last: cand_last, sel: sel_circle, uo: use_other,
              tie: tie_ge};
        if (obs_first < 0) begin
          obs_first   = rs;
          obs_first_b = o;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        if (o !== e) begin
          if (obs_bad == 0) begin
            obs_fm_i = popped; obs_fm_got = o; obs_fm_exp = e;
          end
          obs_bad++;
        end
        popped++;
        if (acc_clr && cand_x == 4'd0 && cand_y == 4'd0)
          obs_pol.push_back({sel_circle, use_other, tie_ge});
        if (cand_last) begin
          obs_lasts++;
          if (cand_x == 4'd15 && cand_y == 4'd15) round_next = 1'b1;
        end
      end else if (acc_clr !== 1'b0 || cand_last !== 1'b0) begin
        obs_bad++;
      end
      if (done === 1'b1) begin
        obs_done_n++;
        obs_done_lat = rs;
        for (int k = 0; k < 4; k++) begin
          @(posedge CLK);
          #1 start = 1'b0;
          @(negedge CLK);
          if (done || busy || in_ready || acc_en) obs_post_bad++;
        end
        return;
      end
      if (rs > budget) begin
        obs_timeout = 1;
        return;
      end
    end
  endtask

  task automatic check_job(input string tag);
    int exp_lat;
    exp_lat = (lat_q.size() > 0) ? lat_q.pop_front() : -2;
    vectors++;
    if (obs_timeout != 0) begin
      miscompares++;
      $display("FAIL %s_timeout: got timeout=%0d required 0", tag, obs_timeout);
    end
    vectors++;
    if (obs_done_lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d required %0d", tag, obs_done_lat, exp_lat);
    end
    vectors++;
    if (obs_bad != 0) begin
      miscompares++;
      $display("FAIL %s_beat_stream: %0d bad beats, first #%0d got %h required %h",
               tag, obs_bad, obs_fm_i, obs_fm_got, obs_fm_exp);
    end
    vectors++;
    if (obs_lasts != NCAND * EXP_ROUNDS) begin
      miscompares++;
      $display("FAIL %s_cand_last_count: got %0d required %0d", tag, obs_lasts, NCAND * EXP_ROUNDS);
    end
    vectors++;
    if (obs_stall_bad != 0) begin
      miscompares++;
      $display("FAIL %s_strobe_in_stall: got %0d required 0", tag, obs_stall_bad);
    end
    vectors++;
    if (obs_busy_bad != 0 || obs_done_n != 1) begin
      miscompares++;
      $display("FAIL %s_busy_done: busy gaps %0d dones %0d required 0 and 1",
               tag, obs_busy_bad, obs_done_n);
    end
    vectors++;
    if (obs_post_bad != 0) begin
      miscompares++;
      $display("FAIL %s_idle_after_done: got %0d active cycles required 0", tag, obs_post_bad);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    vectors++;
    if (all_outs() !== 30'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0", all_outs());
    end
    RST_N = 1'b1;
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (all_outs() !== 30'd0) begin
      miscompares++;
      $display("FAIL idle_ignores_inputs: got %h required 0", all_outs());
    end
    in_valid = 1'b0;
    dp_stall = 1'b0;
  endtask

  task automatic test_load();
    int errs;
    build_model();
    start_job();
    vectors++;
    if ({busy, in_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL start_busy: got %b required 11", {busy, in_ready});
    end
    load_pts(1'b0, errs);
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL load_addr: got %0d bad samples required 0", errs);
    end
  endtask

  task automatic test_full_job();
    logic [2:0] pol_exp[4];
    logic [2:0] got;
    beat_t      fe;
    pol_exp = '{3'b000, 3'b110, 3'b011, 3'b111};
    fe = '{cx: 4'd0, cy: 4'd0, pt: 6'd0, clr: 1'b1, last: 1'b0,
           sel: 1'b0, uo: 1'b0, tie: 1'b0};
    lat_q.push_back(BASE_LAT);
    watch_job(0, 1'b0, 0, 0, 0, BASE_LAT + 100);
    vectors++;
    if (obs_first != NPTS) begin
      miscompares++;
      $display("FAIL scan_entry_cycle: got %0d required %0d", obs_first, NPTS);
    end
    vectors++;
    if (obs_first_b !== fe) begin
      miscompares++;
      $display("FAIL first_strobe: got %h required %h", obs_first_b, fe);
    end
    for (int i = 0; i < EXP_ROUNDS; i++) begin
      got = (obs_pol.size() > i) ? obs_pol[i] : 3'bxxx;
      vectors++;
      if (got !== pol_exp[i]) begin
        miscompares++;
        $display("FAIL round%0d_policy: got %b required %b", i, got, pol_exp[i]);
      end
    end
    check_job("full");
  endtask

  task automatic test_gaps_stall();
    int errs;
    build_model();
    start_job();
    load_pts(1'b1, errs);
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL gap_load_addr: got %0d bad cycles required 0", errs);
    end
    lat_q.push_back(BASE_LAT + NPTS + 3);
    watch_job(3, 1'b1, 1000, 0, 0, BASE_LAT + NPTS + 200);
    check_job("gaps_stall");
  endtask

  task automatic test_abort();
    int errs;
    build_model();
    start_job();
    load_pts(1'b0, errs);
    watch_job(0, 1'b0, 0, 0, 3000, 3100);
    vectors++;
    if (obs_abort_val !== 30'd0) begin
      miscompares++;
      $display("FAIL abort_outputs: got %h required 0", obs_abort_val);
    end
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) errs++;
    end
    RST_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0) errs++;
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d active cycles required 0", errs);
    end
  endtask

  task automatic test_restart_job();
    int errs;
    build_model();
    start_job();
    load_pts(1'b0, errs);
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL restart_load_addr: got %0d bad samples required 0", errs);
    end
    lat_q.push_back(BASE_LAT);
    watch_job(0, 1'b0, 0, BASE_LAT - 1, 0, BASE_LAT + 100);
    check_job("restart");
  endtask

  initial begin
    test_reset();
    test_load();
    test_full_job();
    test_gaps_stall();
    test_abort();
    test_restart_job();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
